// File: rtl/ram_streamer_pkg.sv
// ram_streamer_pkg
//   Memory-map defaults shared with the dual-port RAM instances, plus the
//   address-increment helper used by the read sweep.
//   No ports (package).
package ram_streamer_pkg;

  localparam int unsigned MEM_DATA_WIDTH = 32'd8;
  localparam int unsigned MEM_RAM_SIZE   = 32'd32;

  // Next RAM address with wrap at ram_size-1 (works for non-power-of-2 sizes).
  function automatic int unsigned addr_wrap_inc(input int unsigned addr,
                                                input int unsigned ram_size);
    if (addr >= ram_size - 32'd1) begin
      return 32'd0;
    end else begin
      return addr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/ram_streamer_fifo2.sv
// stream_fifo2
//   Two-entry synchronous FIFO. Head entry is available on o_data whenever
//   o_count is non-zero. Flush has priority over push/pop.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     i_flush      drop all entries
//     i_push       write i_data (caller guarantees not full)
//     i_pop        retire head (caller guarantees not empty)
//     i_data       write data
//     o_data       head entry
//     o_count      number of stored entries (0..2)
module stream_fifo2 #(
  parameter int unsigned WIDTH = 32'd9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem_0;
  logic [WIDTH-1:0] r_mem_1;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_0  <= {WIDTH{1'b0}};
      r_mem_1  <= {WIDTH{1'b0}};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        if (r_wr_ptr) begin
          r_mem_1 <= i_data;
        end else begin
          r_mem_0 <= i_data;
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_rd_ptr ? r_mem_1 : r_mem_0;
  assign o_count = r_count;

endmodule

// File: rtl/ram_streamer.sv
// ram_streamer
//   Read-side master for the dual-port RAM: sweeps `length` consecutive words
//   from `base_addr` (wrapping at RAM_SIZE-1) and streams them over valid/ready.
//   Hides the 1-cycle read latency and discards reads that collided with a
//   CPU write (write-first port returns write data while mem_we is high).
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     start, abort         begin sweep (IDLE only) / cancel sweep (priority)
//     base_addr, length    sweep parameters, sampled with start
//     busy, done           sweep active / one-cycle completion pulse
//     mem_raddr, mem_rdata RAM read address / read data
//     mem_we               snoop of RAM write enable
//     m_valid, m_data, m_last, m_ready   output stream
module ram_streamer
  import ram_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned RAM_SIZE   = MEM_RAM_SIZE,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_we,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [ADDR_WIDTH:0]   r_remaining;   // reads still to be issued
  logic                  r_pend;        // accepted read whose data arrives this cycle
  logic                  r_pend_last;   // that read is the final word of the sweep

  logic [DATA_WIDTH:0]   w_head;
  logic [1:0]            w_fifo_count;
  logic                  w_fifo_valid;
  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic                  w_accept;
  logic                  w_start;
  logic                  w_last_pop;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  assign w_fifo_valid = (w_fifo_count != 2'd0);
  assign w_pop        = w_fifo_valid & m_ready;
  assign w_last_pop   = w_pop & w_head[DATA_WIDTH];
  assign w_start      = (r_state == ST_IDLE) & start & ~abort;

  // Occupancy after this cycle's pop, counting the read whose data is on dout;
  // issuing only below 2 keeps the FIFO from ever overflowing.
  assign w_occ    = {1'b0, w_fifo_count} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_issue  = (r_state == ST_RUN) && (r_remaining != CNT_ZERO) && (w_occ < 3'd2);
  // A read issued while the CPU writes returns write data, so it does not count.
  assign w_accept = w_issue & ~mem_we;
  assign w_push   = r_pend & ~abort;

  assign w_next_addr = ADDR_WIDTH'(addr_wrap_inc(32'(r_raddr), RAM_SIZE));

  // Next-state and done-pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start && (length != CNT_ZERO)) begin
          w_state_nxt = ST_RUN;
        end else if (w_start) begin
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_accept && (r_remaining == CNT_ONE)) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last_pop) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Read address, remaining count and in-flight read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr     <= {ADDR_WIDTH{1'b0}};
      r_remaining <= CNT_ZERO;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else if (abort) begin
      r_remaining <= CNT_ZERO;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      r_pend      <= w_accept;
      r_pend_last <= w_accept && (r_remaining == CNT_ONE);
      if (w_start && (length != CNT_ZERO)) begin
        r_raddr     <= base_addr;
        r_remaining <= length;
      end else if (w_accept) begin
        r_remaining <= r_remaining - CNT_ONE;
        // Hold the final address once the sweep has issued everything.
        if (r_remaining != CNT_ONE) begin
          r_raddr <= w_next_addr;
        end
      end
    end
  end

  stream_fifo2 #(
    .WIDTH(DATA_WIDTH + 32'd1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (abort),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({r_pend_last, mem_rdata}),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign mem_raddr = r_raddr;
  assign m_valid   = w_fifo_valid;
  assign m_data    = w_fifo_valid ? w_head[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
  assign m_last    = w_fifo_valid & w_head[DATA_WIDTH];

endmodule
